// File: rtl/cpu_debug_ctrl.sv
// Debug command controller for a small CPU: accepts host commands,
// sequences continue/register-read/reset pulses and returns one response each.
module cpu_debug_ctrl #(
    parameter int WORD_SIZE     = 18,
    parameter int CONT_CYCLES   = 3,
    parameter int SETTLE_CYCLES = 2,
    parameter int CPURST_CYCLES = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic [3:0]           cmd_arg,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [1:0]           rsp_status,
    output logic [WORD_SIZE-1:0] rsp_data,
    input  logic                 wait_for_continue,
    output logic                 wait_continue_execution,
    output logic                 debug_get_param,
    output logic [3:0]           debug_reg_addr,
    input  logic [WORD_SIZE-1:0] debug_data_out,
    output logic                 cpu_reset
);

    localparam int MAX_A = (CONT_CYCLES > SETTLE_CYCLES) ? CONT_CYCLES : SETTLE_CYCLES;
    localparam int MAX_C = (MAX_A > CPURST_CYCLES) ? MAX_A : CPURST_CYCLES;
    localparam int CW    = (MAX_C < 2) ? 1 : $clog2(MAX_C + 1);

    localparam logic [CW-1:0] CONT_LD   = CW'(CONT_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] CPURST_LD = CW'(CPURST_CYCLES - 1);

    localparam logic [2:0] OP_STATUS    = 3'd0;
    localparam logic [2:0] OP_CONTINUE  = 3'd1;
    localparam logic [2:0] OP_RUN_FREE  = 3'd2;
    localparam logic [2:0] OP_STOP      = 3'd3;
    localparam logic [2:0] OP_READ_REG  = 3'd4;
    localparam logic [2:0] OP_CPU_RESET = 3'd5;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_ILLEGAL = 2'd1;
    localparam logic [1:0] ST_BAD_ARG = 2'd2;
    localparam logic [1:0] ST_NOT_HLT = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        CONT,
        SETTLE,
        CPURST,
        RESP
    } state_e;

    state_e        state;
    logic [CW-1:0] cnt;
    logic          halted;
    logic          free_run;

    // Command FSM with all outputs registered alongside the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state                   <= IDLE;
            cnt                     <= '0;
            halted                  <= 1'b0;
            free_run                <= 1'b0;
            cmd_ready               <= 1'b1;
            rsp_valid               <= 1'b0;
            rsp_status              <= ST_OK;
            rsp_data                <= '0;
            wait_continue_execution <= 1'b0;
            debug_get_param         <= 1'b0;
            debug_reg_addr          <= '0;
            cpu_reset               <= 1'b0;
        end else begin
            // The CPU parks on a wait instruction; remember it unless we are releasing it.
            if (wait_for_continue && state != CONT) begin
                halted <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready  <= 1'b0;
                        rsp_status <= ST_OK;
                        rsp_data   <= '0;
                        unique case (cmd_op)
                            OP_STATUS: begin
                                state     <= RESP;
                                rsp_valid <= 1'b1;
                                rsp_data  <= {{(WORD_SIZE-2){1'b0}}, free_run, halted};
                            end
                            OP_CONTINUE: begin
                                if (free_run) begin
                                    state     <= RESP;
                                    rsp_valid <= 1'b1;
                                end else if (halted) begin
                                    state                   <= CONT;
                                    cnt                     <= CONT_LD;
                                    halted                  <= 1'b0;
                                    wait_continue_execution <= 1'b1;
                                end else begin
                                    state      <= RESP;
                                    rsp_valid  <= 1'b1;
                                    rsp_status <= ST_NOT_HLT;
                                end
                            end
                            OP_RUN_FREE: begin
                                state                   <= RESP;
                                rsp_valid               <= 1'b1;
                                free_run                <= 1'b1;
                                wait_continue_execution <= 1'b1;
                            end
                            OP_STOP: begin
                                state                   <= RESP;
                                rsp_valid               <= 1'b1;
                                free_run                <= 1'b0;
                                wait_continue_execution <= 1'b0;
                            end
                            OP_READ_REG: begin
                                if (cmd_arg <= 4'd8) begin
                                    state           <= SETTLE;
                                    cnt             <= SETTLE_LD;
                                    debug_reg_addr  <= cmd_arg;
                                    debug_get_param <= 1'b1;
                                end else begin
                                    state      <= RESP;
                                    rsp_valid  <= 1'b1;
                                    rsp_status <= ST_BAD_ARG;
                                end
                            end
                            OP_CPU_RESET: begin
                                state                   <= CPURST;
                                cnt                     <= CPURST_LD;
                                halted                  <= 1'b0;
                                free_run                <= 1'b0;
                                wait_continue_execution <= 1'b0;
                                cpu_reset               <= 1'b1;
                            end
                            default: begin
                                state      <= RESP;
                                rsp_valid  <= 1'b1;
                                rsp_status <= ST_ILLEGAL;
                            end
                        endcase
                    end
                end
                CONT: begin
                    if (cnt == '0) begin
                        state                   <= RESP;
                        rsp_valid               <= 1'b1;
                        wait_continue_execution <= free_run;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        state           <= RESP;
                        rsp_valid       <= 1'b1;
                        rsp_data        <= debug_data_out;
                        debug_get_param <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                CPURST: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        cpu_reset <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Bench for cpu_debug_ctrl: directed vector table, reset corner cases,
// then random commands checked against a transaction-level model.
module tb_cpu_debug_ctrl;

    localparam int W   = 18;
    localparam int CC  = 3;
    localparam int SC  = 2;
    localparam int RC  = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = '0;
    logic [3:0]    cmd_arg = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [1:0]    rsp_status;
    logic [W-1:0]  rsp_data;
    logic          wait_for_continue = 1'b0;
    logic          wait_continue_execution;
    logic          debug_get_param;
    logic [3:0]    debug_reg_addr;
    logic [W-1:0]  debug_data_out = '0;
    logic          cpu_reset;

    cpu_debug_ctrl #(
        .WORD_SIZE(W), .CONT_CYCLES(CC), .SETTLE_CYCLES(SC), .CPURST_CYCLES(RC)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_status(rsp_status), .rsp_data(rsp_data),
        .wait_for_continue(wait_for_continue),
        .wait_continue_execution(wait_continue_execution),
        .debug_get_param(debug_get_param),
        .debug_reg_addr(debug_reg_addr),
        .debug_data_out(debug_data_out),
        .cpu_reset(cpu_reset)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]   st;
        logic [W-1:0] data;
        int           lat;
        int           wce;
        int           dgp;
        int           rst;
        bit           fr;
    } exp_t;

    typedef struct {
        logic [2:0]   op;
        logic [3:0]   arg;
        logic [W-1:0] din;
        bit           wfc;
        logic [1:0]   st;
        logic [W-1:0] data;
        int           lat;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;
    bit m_h    = 1'b0;
    bit m_fr   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level model: flags plus expected response and pulse lengths.
    task automatic model_step(input logic [2:0] op, input logic [3:0] arg,
                              input logic [W-1:0] din, output exp_t e);
        bit released;
        released = 1'b0;
        e = '{st: 2'd0, data: '0, lat: 1, wce: 0, dgp: 0, rst: 0, fr: 1'b0};
        case (op)
            3'd0: e.data = W'({m_fr, m_h});
            3'd1: begin
                if (m_fr) begin
                end else if (m_h) begin
                    released = 1'b1;
                    e.lat = CC + 1;
                    e.wce = CC;
                    m_h = 1'b0;
                end else begin
                    e.st = 2'd3;
                end
            end
            3'd2: m_fr = 1'b1;
            3'd3: m_fr = 1'b0;
            3'd4: begin
                if (arg <= 4'd8) begin
                    e.lat  = SC + 1;
                    e.dgp  = SC;
                    e.data = din;
                end else begin
                    e.st = 2'd2;
                end
            end
            3'd5: begin
                e.lat = RC + 1;
                e.rst = RC;
                m_h  = 1'b0;
                m_fr = 1'b0;
            end
            default: e.st = 2'd1;
        endcase
        e.fr = m_fr;
        if (!released) e.wce = m_fr ? e.lat - 1 : 0;
    endtask

    task automatic pulse_wfc();
        wait_for_continue = 1'b1;
        @(negedge clock);
        wait_for_continue = 1'b0;
        m_h = 1'b1;
    endtask

    // Issue one command from IDLE, watch the sequence, stall, then take the response.
    task automatic run_cmd(input logic [2:0] op, input logic [3:0] arg,
                           input logic [W-1:0] din, input int stall, input exp_t e);
        int lat, nw, nd, nr;
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_arg = arg;
        debug_data_out = din;
        @(negedge clock);
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom);
        cmd_arg = 4'($urandom);
        lat = 1; nw = 0; nd = 0; nr = 0;
        while (!rsp_valid && lat < 64) begin
            nw += int'(wait_continue_execution);
            nd += int'(debug_get_param);
            nr += int'(cpu_reset);
            if (debug_get_param) chk("reg_addr", debug_reg_addr, arg);
            @(negedge clock);
            lat++;
        end
        if (!rsp_valid) begin
            n_chk++;
            n_fail++;
            $display("FAIL rsp_timeout: op %0d got no response, expected within %0d", op, e.lat);
            return;
        end
        chk("latency", lat, e.lat);
        chk("status", rsp_status, e.st);
        chk("data", rsp_data, e.data);
        chk("wce_cycles", nw, e.wce);
        chk("dgp_cycles", nd, e.dgp);
        chk("cpurst_cycles", nr, e.rst);
        chk("wce_in_resp", wait_continue_execution, e.fr);
        chk("dgp_in_resp", debug_get_param, 0);
        chk("cmd_ready_resp", cmd_ready, 0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            chk("stall_valid", rsp_valid, 1);
            chk("stall_status", rsp_status, e.st);
            chk("stall_data", rsp_data, e.data);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        chk("rsp_done", rsp_valid, 0);
        chk("cmd_ready_after", cmd_ready, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_wce"}, wait_continue_execution, 0);
        chk({tag, "_dgp"}, debug_get_param, 0);
        chk({tag, "_cpu_reset"}, cpu_reset, 0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        m_h  = 1'b0;
        m_fr = 1'b0;
    endtask

    vec_t tbl[15];

    initial begin
        exp_t e;
        int   cnt;

        tbl[0]  = '{3'd0, 4'd0, 18'h0,     1'b0, 2'd0, 18'h0,     1};
        tbl[1]  = '{3'd1, 4'd0, 18'h0,     1'b0, 2'd3, 18'h0,     1};
        tbl[2]  = '{3'd1, 4'd0, 18'h0,     1'b1, 2'd0, 18'h0,     CC + 1};
        tbl[3]  = '{3'd4, 4'd8, 18'h00123, 1'b0, 2'd0, 18'h00123, SC + 1};
        tbl[4]  = '{3'd4, 4'd9, 18'h3ffff, 1'b0, 2'd2, 18'h0,     1};
        tbl[5]  = '{3'd7, 4'd0, 18'h0,     1'b0, 2'd1, 18'h0,     1};
        tbl[6]  = '{3'd6, 4'd3, 18'h0,     1'b0, 2'd1, 18'h0,     1};
        tbl[7]  = '{3'd2, 4'd0, 18'h0,     1'b0, 2'd0, 18'h0,     1};
        tbl[8]  = '{3'd0, 4'd0, 18'h0,     1'b0, 2'd0, 18'h2,     1};
        tbl[9]  = '{3'd1, 4'd0, 18'h0,     1'b0, 2'd0, 18'h0,     1};
        tbl[10] = '{3'd3, 4'd0, 18'h0,     1'b0, 2'd0, 18'h0,     1};
        tbl[11] = '{3'd0, 4'd0, 18'h0,     1'b1, 2'd0, 18'h1,     1};
        tbl[12] = '{3'd5, 4'd0, 18'h0,     1'b0, 2'd0, 18'h0,     RC + 1};
        tbl[13] = '{3'd0, 4'd0, 18'h0,     1'b0, 2'd0, 18'h0,     1};
        tbl[14] = '{3'd4, 4'd0, 18'h3ffff, 1'b0, 2'd0, 18'h3ffff, SC + 1};

        repeat (2) @(negedge clock);
        reset = 1'b0;
        check_reset_outputs("reset");
        chk("reset_status", rsp_status, 0);
        chk("reset_data", rsp_data, 0);
        chk("reset_addr", debug_reg_addr, 0);

        foreach (tbl[i]) begin
            if (tbl[i].wfc) pulse_wfc();
            model_step(tbl[i].op, tbl[i].arg, tbl[i].din, e);
            e.st   = tbl[i].st;
            e.data = tbl[i].data;
            e.lat  = tbl[i].lat;
            run_cmd(tbl[i].op, tbl[i].arg, tbl[i].din, i % 3, e);
        end

        // Reset in the middle of a CONTINUE release.
        pulse_wfc();
        cmd_valid = 1'b1;
        cmd_op = 3'd1;
        @(negedge clock);
        cmd_valid = 1'b0;
        chk("cont_wce_high", wait_continue_execution, 1);
        @(negedge clock);
        apply_reset();
        check_reset_outputs("cont_abort");
        cnt = 0;
        repeat (6) begin
            @(negedge clock);
            cnt += int'(rsp_valid) + int'(wait_continue_execution);
        end
        chk("cont_abort_quiet", cnt, 0);

        // Stalled response, then reset in the middle of CPU_RESET.
        model_step(3'd2, 4'd0, '0, e);
        run_cmd(3'd2, 4'd0, '0, 0, e);
        model_step(3'd0, 4'd0, '0, e);
        run_cmd(3'd0, 4'd0, '0, 5, e);
        cmd_valid = 1'b1;
        cmd_op = 3'd5;
        @(negedge clock);
        cmd_valid = 1'b0;
        chk("cpurst_high", cpu_reset, 1);
        chk("cpurst_wce_low", wait_continue_execution, 0);
        @(negedge clock);
        apply_reset();
        check_reset_outputs("cpurst_abort");
        cnt = 0;
        repeat (6) begin
            @(negedge clock);
            cnt += int'(rsp_valid) + int'(cpu_reset);
        end
        chk("cpurst_abort_quiet", cnt, 0);
        model_step(3'd0, 4'd0, '0, e);
        run_cmd(3'd0, 4'd0, '0, 0, e);

        // Random command stream against the model.
        for (int k = 0; k < 200; k++) begin
            logic [2:0]   op;
            logic [3:0]   arg;
            logic [W-1:0] din;
            op  = 3'($urandom_range(0, 7));
            arg = 4'($urandom_range(0, 11));
            din = W'($urandom);
            if ($urandom_range(0, 2) == 0) pulse_wfc();
            model_step(op, arg, din, e);
            run_cmd(op, arg, din, $urandom_range(0, 3), e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
